// File: rtl/cluster_frame_packer_if.sv
// Bunch-crossing cluster results into the frame packer, serialized frame words out.
interface cluster_frame_packer_if;
  logic        latch_pulse;
  logic [10:0] adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7;
  logic [2:0]  cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7;
  logic        bc0;
  logic        resync;
  logic [31:0] frame_word;
  logic        frame_valid;
  logic        sof;
  logic [7:0]  err_cnt;

  modport master (
    output latch_pulse,
    output adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7,
    output cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7,
    output bc0, resync,
    input  frame_word, frame_valid, sof, err_cnt
  );

  modport slave (
    input  latch_pulse,
    input  adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7,
    input  cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7,
    input  bc0, resync,
    output frame_word, frame_valid, sof, err_cnt
  );
endinterface

// File: rtl/cluster_frame_packer.sv
// Captures eight clusters plus a header on each latch pulse and streams the
// resulting 128-bit frame out as four 32-bit words, word 0 first.
//
//   state  | meaning
//   S_IDLE | no frame in flight, IDLE_WORD on the output
//   S_RUN  | frame word slot_q on the output
module cluster_frame_packer #(
  parameter logic [31:0] IDLE_WORD   = 32'hBC50_BC50,
  parameter logic [10:0] INVALID_ADR = 11'h7FF
) (
  input logic                   clock4x,
  input logic                   global_reset,
  cluster_frame_packer_if.slave bus
);

  localparam logic [10:0] ADR_LIMIT = 11'd1536;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [127:0] frame_q, frame_d;
  logic [31:0]  frame_word_q, frame_word_d;
  logic         frame_valid_q, frame_valid_d;
  logic         sof_q, sof_d;
  logic [7:0]   err_cnt_q, err_cnt_d;
  logic [7:0]   bxn_q, bxn_d;
  logic         rs_flag_q, rs_flag_d;
  logic         bxn_clr_q, bxn_clr_d;
  logic         armed_q, armed_d;

  logic [10:0]  adr_a [8];
  logic [2:0]   cnt_a [8];
  logic [13:0]  slot_w [8];
  logic [7:0]   slot_ok;
  logic [111:0] clusters;
  logic [3:0]   ncl;
  logic         accept;
  logic         misalign;
  logic [7:0]   bxn_new;
  logic [127:0] frame_new;

  assign adr_a[0] = bus.adr0;
  assign adr_a[1] = bus.adr1;
  assign adr_a[2] = bus.adr2;
  assign adr_a[3] = bus.adr3;
  assign adr_a[4] = bus.adr4;
  assign adr_a[5] = bus.adr5;
  assign adr_a[6] = bus.adr6;
  assign adr_a[7] = bus.adr7;
  assign cnt_a[0] = bus.cnt0;
  assign cnt_a[1] = bus.cnt1;
  assign cnt_a[2] = bus.cnt2;
  assign cnt_a[3] = bus.cnt3;
  assign cnt_a[4] = bus.cnt4;
  assign cnt_a[5] = bus.cnt5;
  assign cnt_a[6] = bus.cnt6;
  assign cnt_a[7] = bus.cnt7;

  for (genvar g = 0; g < 8; g++) begin : g_slot
    assign slot_ok[g] = adr_a[g] < ADR_LIMIT;
    assign slot_w[g]  = slot_ok[g] ? {cnt_a[g], adr_a[g]} : {3'd0, INVALID_ADR};
  end

  assign clusters = {slot_w[0], slot_w[1], slot_w[2], slot_w[3],
                     slot_w[4], slot_w[5], slot_w[6], slot_w[7]};
  assign ncl      = 4'($countones(slot_ok));

  // armed_q blocks a latch pulse on the first edge after reset release.
  assign accept    = bus.latch_pulse & ~bus.resync & armed_q;
  assign misalign  = accept & (state_q == S_RUN) & (slot_q != 2'd3);
  assign bxn_new   = (bus.bc0 | bxn_clr_q) ? 8'd0 : bxn_q + 8'd1;
  assign frame_new = {bus.bc0, rs_flag_q, misalign, 1'b0, ncl, bxn_new, clusters};

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      state_q <= S_IDLE;
      slot_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (bus.resync) begin
      state_d = S_IDLE;
      slot_d  = 2'd0;
    end else if (accept) begin
      state_d = S_RUN;
      slot_d  = 2'd0;
    end else if (state_q == S_RUN) begin
      if (slot_q == 2'd3) begin
        state_d = S_IDLE;
        slot_d  = 2'd0;
      end else begin
        slot_d = slot_q + 2'd1;
      end
    end
  end

  always_comb begin
    frame_word_d  = IDLE_WORD;
    frame_valid_d = 1'b0;
    sof_d         = 1'b0;
    if (state_d == S_RUN) begin
      frame_valid_d = 1'b1;
      sof_d         = (slot_d == 2'd0);
      case (slot_d)
        2'd0:    frame_word_d = frame_d[127:96];
        2'd1:    frame_word_d = frame_d[95:64];
        2'd2:    frame_word_d = frame_d[63:32];
        default: frame_word_d = frame_d[31:0];
      endcase
    end
  end

  // Resync parks the counter at zero and flags the first frame that follows it.
  always_comb begin
    frame_d   = frame_q;
    bxn_d     = bxn_q;
    bxn_clr_d = bxn_clr_q;
    rs_flag_d = rs_flag_q;
    err_cnt_d = err_cnt_q;
    armed_d   = 1'b1;
    if (bus.resync) begin
      bxn_d     = 8'd0;
      bxn_clr_d = 1'b1;
      rs_flag_d = 1'b1;
    end else if (accept) begin
      frame_d   = frame_new;
      bxn_d     = bxn_new;
      bxn_clr_d = 1'b0;
      rs_flag_d = 1'b0;
      if (misalign && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      frame_q       <= '0;
      frame_word_q  <= IDLE_WORD;
      frame_valid_q <= 1'b0;
      sof_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
      bxn_q         <= 8'd0;
      bxn_clr_q     <= 1'b1;
      rs_flag_q     <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      frame_word_q  <= frame_word_d;
      frame_valid_q <= frame_valid_d;
      sof_q         <= sof_d;
      err_cnt_q     <= err_cnt_d;
      bxn_q         <= bxn_d;
      bxn_clr_q     <= bxn_clr_d;
      rs_flag_q     <= rs_flag_d;
      armed_q       <= armed_d;
    end
  end

  assign bus.frame_word  = frame_word_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sof         = sof_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_cluster_frame_packer.sv
// Directed bench for cluster_frame_packer: single frame, back-to-back stream,
// misalignment, resync, occupancy boundaries and asynchronous reset.
module tb_cluster_frame_packer;
  localparam logic [31:0] IDLE_WORD = 32'hBC50_BC50;

  logic        clock4x      = 1'b0;
  logic        global_reset = 1'b1;
  logic [10:0] tb_adr [8];
  logic [2:0]  tb_cnt [8];
  int          n_vec = 0;
  int          n_err = 0;
  logic [127:0] fa;

  cluster_frame_packer_if bus ();

  assign bus.adr0 = tb_adr[0];
  assign bus.adr1 = tb_adr[1];
  assign bus.adr2 = tb_adr[2];
  assign bus.adr3 = tb_adr[3];
  assign bus.adr4 = tb_adr[4];
  assign bus.adr5 = tb_adr[5];
  assign bus.adr6 = tb_adr[6];
  assign bus.adr7 = tb_adr[7];
  assign bus.cnt0 = tb_cnt[0];
  assign bus.cnt1 = tb_cnt[1];
  assign bus.cnt2 = tb_cnt[2];
  assign bus.cnt3 = tb_cnt[3];
  assign bus.cnt4 = tb_cnt[4];
  assign bus.cnt5 = tb_cnt[5];
  assign bus.cnt6 = tb_cnt[6];
  assign bus.cnt7 = tb_cnt[7];

  cluster_frame_packer #(
    .IDLE_WORD   (IDLE_WORD),
    .INVALID_ADR (11'h7FF)
  ) dut (
    .clock4x      (clock4x),
    .global_reset (global_reset),
    .bus          (bus)
  );

  always #3 clock4x = ~clock4x;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock4x);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " word"}, bus.frame_word, IDLE_WORD);
    chk({tag, " valid"}, 32'(bus.frame_valid), 32'd0);
    chk({tag, " sof"}, 32'(bus.sof), 32'd0);
  endtask

  task automatic chk_hdr(input string tag, input logic [31:0] exp);
    chk({tag, " header"}, 32'(bus.frame_word[31:16]), exp);
  endtask

  // Word 0 must already be on the output; returns with word 3 on the output.
  task automatic expect_frame(input string tag, input logic [127:0] f);
    logic [127:0] sh;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) step();
      sh = f << (32 * k);
      chk({tag, " word"}, bus.frame_word, sh[127:96]);
      chk({tag, " sof"}, 32'(bus.sof), 32'(k == 0));
      chk({tag, " valid"}, 32'(bus.frame_valid), 32'd1);
    end
  endtask

  function automatic logic [127:0] pack(input logic b, input logic r, input logic e,
                                        input logic [7:0] bx);
    logic [111:0] cl;
    logic [3:0]   n;
    logic [13:0]  c;
    cl = '0;
    n  = '0;
    for (int i = 0; i < 8; i++) begin
      if (tb_adr[i[2:0]] <= 11'd1535) begin
        c = {tb_cnt[i[2:0]], tb_adr[i[2:0]]};
        n = n + 4'd1;
      end else begin
        c = 14'h07FF;
      end
      cl = {cl[97:0], c};
    end
    return {b, r, e, 1'b0, n, bx, cl};
  endfunction

  task automatic set_all_invalid();
    for (int i = 0; i < 8; i++) begin
      tb_adr[i[2:0]] = 11'd1536;
      tb_cnt[i[2:0]] = 3'd0;
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) begin
      tb_adr[i[2:0]] = 11'(i * 200 + 7);
      tb_cnt[i[2:0]] = 3'(i);
    end
  endtask

  task automatic pulse(input logic b);
    bus.latch_pulse = 1'b1;
    bus.bc0         = b;
    step();
    bus.latch_pulse = 1'b0;
    bus.bc0         = 1'b0;
  endtask

  initial begin
    bus.latch_pulse = 1'b0;
    bus.bc0         = 1'b0;
    bus.resync      = 1'b0;
    set_all_invalid();

    // reset state, then a latch pulse on the release edge is dropped
    step();
    step();
    chk_idle("reset");
    chk("reset err_cnt", 32'(bus.err_cnt), 32'd0);
    global_reset    = 1'b0;
    bus.latch_pulse = 1'b1;
    step();
    bus.latch_pulse = 1'b0;
    chk_idle("release latch");

    // single frame; inputs change after capture and must not leak in
    tb_adr[0] = 11'd5;
    tb_cnt[0] = 3'd2;
    pulse(1'b1);
    tb_adr[0] = 11'd9;
    tb_cnt[0] = 3'd7;
    expect_frame("single", {16'h8100, 14'h1005, {7{14'h07FF}}});
    step();
    chk_idle("single end");

    // 260 back-to-back frames, bxn wraps 255 -> 0
    set_ramp();
    for (int f = 0; f < 260; f++) begin
      pulse(f == 0);
      if (f == 0)   chk_hdr("b2b first", 32'h8800);
      if (f == 256) chk_hdr("b2b wrap", 32'h0800);
      expect_frame("b2b", pack(f == 0, 1'b0, 1'b0, 8'(f)));
    end
    step();
    chk_idle("b2b end");
    chk("b2b err_cnt", 32'(bus.err_cnt), 32'd0);

    // 1535 counts as valid, 1536 does not
    set_ramp();
    tb_adr[0] = 11'd1535;
    tb_adr[1] = 11'd1536;
    pulse(1'b0);
    chk_hdr("occ7", 32'h0704);
    expect_frame("occ7", pack(1'b0, 1'b0, 1'b0, 8'd4));
    step();
    tb_adr[1] = 11'd1535;
    pulse(1'b0);
    chk_hdr("occ8", 32'h0805);
    expect_frame("occ8", pack(1'b0, 1'b0, 1'b0, 8'd5));
    step();
    chk_idle("occ end");

    // misaligned pulse two cycles into frame A, carrying bc0 as well
    set_ramp();
    fa = pack(1'b0, 1'b0, 1'b0, 8'd6);
    pulse(1'b0);
    chk("misA w0", bus.frame_word, fa[127:96]);
    step();
    chk("misA w1", bus.frame_word, fa[95:64]);
    pulse(1'b1);
    chk_hdr("misB", 32'hA800);
    chk("misB err_cnt", 32'(bus.err_cnt), 32'd1);
    expect_frame("misB", pack(1'b1, 1'b0, 1'b1, 8'd0));
    step();
    chk_idle("misB end");

    // error counter saturates
    for (int p = 0; p < 300; p++) begin
      pulse(1'b0);
      step();
    end
    chk("err_cnt sat", 32'(bus.err_cnt), 32'd255);
    repeat (3) step();
    chk_idle("sat end");

    // resync mid-frame with pulses present
    pulse(1'b0);
    step();
    bus.resync      = 1'b1;
    bus.latch_pulse = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle("resync during");
    end
    bus.resync      = 1'b0;
    bus.latch_pulse = 1'b0;
    step();
    chk_idle("resync after");
    pulse(1'b0);
    chk_hdr("resync f1", 32'h4800);
    expect_frame("resync f1", pack(1'b0, 1'b1, 1'b0, 8'd0));
    pulse(1'b0);
    chk_hdr("resync f2", 32'h0801);
    expect_frame("resync f2", pack(1'b0, 1'b0, 1'b0, 8'd1));
    step();
    chk_idle("resync end");

    // asynchronous reset while word 2 is on the output
    pulse(1'b0);
    step();
    step();
    chk("pre-reset valid", 32'(bus.frame_valid), 32'd1);
    global_reset = 1'b1;
    #1;
    chk_idle("async reset");
    chk("async reset err_cnt", 32'(bus.err_cnt), 32'd0);
    step();
    global_reset = 1'b0;
    step();
    pulse(1'b0);
    chk_hdr("post-reset", 32'h0800);
    expect_frame("post-reset", pack(1'b0, 1'b0, 1'b0, 8'd0));
    step();
    chk_idle("post-reset end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
